// File: rtl/block_mem_responder.sv
// -----------------------------------------------------------------------------
// block_mem_responder
//
// Block-granular (256-bit / 32-byte) backing store that answers the data-side
// block port of the pipelined core. One block read or block write is in flight
// at a time. Each one completes LATENCY cycles after acceptance with a one-cycle
// valid pulse, so cache controllers see realistic miss and writeback timing.
//
// Parameters
//   DEPTH_LOG2  log2 of the number of stored blocks (default 1024 blocks)
//   LATENCY     cycles from acceptance to the valid pulse, 1..255
//
// Ports
//   CLK                    system clock, rising edge
//   RESET                  synchronous, active-high reset
//   dBlkRead               block read request (level)
//   dBlkWrite              block write request (level), wins over dBlkRead
//   data_address_2DM       byte address; bits [DEPTH_LOG2+4:5] select the block
//   block_write_2DM        block data for writes
//   block_read_fDM         registered read data, held until the next read completes
//   block_read_fDM_valid   one-cycle pulse: read complete
//   block_write_fDM_valid  one-cycle pulse: write committed
//   busy                   high while a transaction is in BUSY or DONE
// -----------------------------------------------------------------------------
module block_mem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         dBlkRead,
    input  logic         dBlkWrite,
    input  logic [31:0]  data_address_2DM,
    input  logic [255:0] block_write_2DM,
    output logic [255:0] block_read_fDM,
    output logic         block_read_fDM_valid,
    output logic         block_write_fDM_valid,
    output logic         busy
);

    localparam int         NUM_BLOCKS = 1 << DEPTH_LOG2;
    localparam logic [7:0] CNT_LOAD   = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [7:0]              cnt_reg, cnt_next;
    logic                    op_write_reg, op_write_next;
    logic [DEPTH_LOG2-1:0]   idx_reg, idx_next;
    logic [255:0]            wdata_reg, wdata_next;
    logic                    rvalid_reg, rvalid_next;
    logic                    wvalid_reg, wvalid_next;
    logic                    busy_reg;
    logic [255:0]            rdata_reg;
    logic                    commit_write;
    logic                    launch_read;
    logic                    req_active;

    // Backing store: no reset, contents survive RESET.
    logic [255:0] mem [0:NUM_BLOCKS-1];

    // Byte-offset bits and the address bits above the block index are
    // deliberately discarded (addresses wrap modulo the block count).
    logic unused_addr_bits;
    assign unused_addr_bits = ^data_address_2DM;

    // -------------------------------------------------------------------------
    // Next-state / datapath control
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        op_write_next = op_write_reg;
        idx_next      = idx_reg;
        wdata_next    = wdata_reg;
        rvalid_next   = 1'b0;
        wvalid_next   = 1'b0;
        commit_write  = 1'b0;
        launch_read   = 1'b0;
        // The request line belonging to the accepted operation must stay high
        // for the whole BUSY phase; dropping it cancels the transaction.
        req_active    = op_write_reg ? dBlkWrite : dBlkRead;

        case (state_reg)
            ST_IDLE: begin
                if (dBlkWrite) begin
                    op_write_next = 1'b1;
                    idx_next      = data_address_2DM[DEPTH_LOG2+4:5];
                    wdata_next    = block_write_2DM;
                    cnt_next      = CNT_LOAD;
                    state_next    = ST_BUSY;
                end else if (dBlkRead) begin
                    op_write_next = 1'b0;
                    idx_next      = data_address_2DM[DEPTH_LOG2+4:5];
                    cnt_next      = CNT_LOAD;
                    state_next    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!req_active) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg != 8'd0) begin
                    cnt_next = cnt_reg - 8'd1;
                end else begin
                    state_next = ST_DONE;
                    if (op_write_reg) begin
                        commit_write = 1'b1;
                        wvalid_next  = 1'b1;
                    end else begin
                        launch_read  = 1'b1;
                        rvalid_next  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // Requests are ignored here; the requester drops its line on
                // the edge at which it samples valid.
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= 8'd0;
            rvalid_reg <= 1'b0;
            wvalid_reg <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            rvalid_reg <= rvalid_next;
            wvalid_reg <= wvalid_next;
            busy_reg   <= (state_next != ST_IDLE);
        end
    end

    // Latched operands need no reset: they are only consumed after acceptance.
    always_ff @(posedge CLK) begin
        op_write_reg <= op_write_next;
        idx_reg      <= idx_next;
        wdata_reg    <= wdata_next;
    end

    // -------------------------------------------------------------------------
    // Block RAM: write port commits at the DONE entry edge, read port is
    // registered. A reset on the same edge suppresses an in-flight commit.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (commit_write && !RESET) begin
            mem[idx_reg] <= wdata_reg;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rdata_reg <= '0;
        end else if (launch_read) begin
            rdata_reg <= mem[idx_reg];
        end
    end

    assign block_read_fDM        = rdata_reg;
    assign block_read_fDM_valid  = rvalid_reg;
    assign block_write_fDM_valid = wvalid_reg;
    assign busy                  = busy_reg;

endmodule
